multicycle_ctrl: RTL and testbench

Multi-cycle sequencing controller for the RV32I core. It replaces per-instruction combinational decode with a FETCH/DECODE/EXEC/MEM/WB state machine. It drives the same datapath strobes (RegWr, ALUSrc, MemWr, MemRead, MemtoReg, UncondJump, ALUOp, PCSrc) plus IR/PC write enables. It also handshakes with a single shared instruction/data memory port.

---
 rtl/multicycle_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core sharing one memory port.
// Define MULTICYCLE_PERF_EN to add the cycle_cnt / instret_cnt performance counters.
module multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  opcode,
   input  logic        mem_ready,
   input  logic        branch_taken,
   output logic        mem_req,
   output logic        mem_is_instr,
   output logic        MemRead,
   output logic        MemWr,
   output logic        IRWr,
   output logic        PCWr,
   output logic [1:0]  PCSrc,
   output logic        RegWr,
   output logic        MemtoReg,
   output logic        UncondJump,
   output logic        ALUSrc,
   output logic [1:0]  ALUOp,
   output logic [2:0]  state,
   output logic        illegal,
   output logic        retire
`ifdef MULTICYCLE_PERF_EN
   ,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instret_cnt
`endif
);

   localparam logic [2:0] FETCH  = 3'd0;
   localparam logic [2:0] DECODE = 3'd1;
   localparam logic [2:0] EXEC   = 3'd2;
   localparam logic [2:0] MEM    = 3'd3;
   localparam logic [2:0] WB     = 3'd4;
   localparam logic [2:0] ERROR  = 3'd7;

   localparam logic [6:0] OP_BTYPE = 7'b1100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   logic [2:0] r_state;
   logic [2:0] w_next;
   logic [6:0] r_opQ;
   logic [7:0] r_waitCnt;
   logic       r_illegal;
   logic       w_waiting;
   logic       w_timeout;
   logic       w_supported;
   logic       w_aluSrc;
   logic [1:0] w_aluOp;

   assign w_supported = (opcode == OP_BTYPE) || (opcode == OP_RTYPE) || (opcode == OP_STORE) ||
                        (opcode == OP_LOAD)  || (opcode == OP_ITYPE) || (opcode == OP_JAL)   ||
                        (opcode == OP_JALR);

   // The last permitted wait cycle is the one where the counter already holds MEM_TIMEOUT-1,
   // so exactly MEM_TIMEOUT unanswered cycles lead to ERROR unless mem_ready arrives.
   assign w_waiting = ((r_state == FETCH) || (r_state == MEM)) && !mem_ready;
   assign w_timeout = w_waiting && (r_waitCnt == 8'(MEM_TIMEOUT - 1));

   always_comb begin
      w_aluSrc = 1'b1;
      w_aluOp  = 2'b00;
      case (r_opQ)
         OP_BTYPE: begin w_aluSrc = 1'b0; w_aluOp = 2'b01; end
         OP_RTYPE: begin w_aluSrc = 1'b0; w_aluOp = 2'b10; end
         OP_ITYPE: begin w_aluSrc = 1'b1; w_aluOp = 2'b11; end
         default:  ;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         FETCH:  w_next = mem_ready ? DECODE : (w_timeout ? ERROR : FETCH);
         DECODE: w_next = w_supported ? EXEC : ERROR;
         EXEC: begin
            case (r_opQ)
               OP_BTYPE, OP_JAL, OP_JALR: w_next = FETCH;
               OP_LOAD, OP_STORE:         w_next = MEM;
               OP_RTYPE, OP_ITYPE:        w_next = WB;
               default:                   w_next = ERROR;
            endcase
         end
         MEM: begin
            if (mem_ready)      w_next = (r_opQ == OP_LOAD) ? WB : FETCH;
            else if (w_timeout) w_next = ERROR;
         end
         WB:      w_next = FETCH;
         default: w_next = ERROR;
      endcase
   end

   // Strobes are forced low while rst is high so a write in flight drops immediately.
   always_comb begin
      mem_req      = 1'b0;
      mem_is_instr = 1'b0;
      MemRead      = 1'b0;
      MemWr        = 1'b0;
      IRWr         = 1'b0;
      PCWr         = 1'b0;
      PCSrc        = 2'b00;
      RegWr        = 1'b0;
      MemtoReg     = 1'b0;
      UncondJump   = 1'b0;
      ALUSrc       = 1'b0;
      ALUOp        = 2'b00;
      retire       = 1'b0;
      state        = r_state;
      illegal      = r_illegal;
      if (!rst) begin
         case (r_state)
            FETCH: begin
               mem_req      = 1'b1;
               mem_is_instr = 1'b1;
               MemRead      = 1'b1;
               IRWr         = mem_ready;
               PCWr         = mem_ready;
            end
            EXEC: begin
               ALUSrc = w_aluSrc;
               ALUOp  = w_aluOp;
               case (r_opQ)
                  OP_BTYPE: begin
                     PCWr   = branch_taken;
                     PCSrc  = 2'b01;
                     retire = 1'b1;
                  end
                  OP_JAL, OP_JALR: begin
                     PCWr       = 1'b1;
                     PCSrc      = (r_opQ == OP_JALR) ? 2'b10 : 2'b01;
                     RegWr      = 1'b1;
                     UncondJump = 1'b1;
                     retire     = 1'b1;
                  end
                  default: ;
               endcase
            end
            MEM: begin
               mem_req = 1'b1;
               ALUSrc  = 1'b1;
               MemRead = (r_opQ == OP_LOAD);
               MemWr   = (r_opQ == OP_STORE);
               retire  = mem_ready && (r_opQ == OP_STORE);
            end
            WB: begin
               RegWr    = 1'b1;
               MemtoReg = (r_opQ == OP_LOAD);
               ALUSrc   = w_aluSrc;
               ALUOp    = w_aluOp;
               retire   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= FETCH;
         r_opQ     <= 7'd0;
         r_waitCnt <= 8'd0;
         r_illegal <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_waitCnt <= w_waiting ? (r_waitCnt + 8'd1) : 8'd0;
         if (r_state == DECODE) r_opQ <= opcode;
         if (w_next == ERROR) r_illegal <= 1'b1;
      end
   end

`ifdef MULTICYCLE_PERF_EN
   logic [31:0] r_cycleCnt;
   logic [31:0] r_instretCnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cycleCnt   <= 32'd0;
         r_instretCnt <= 32'd0;
      end else begin
         if (r_state != ERROR) r_cycleCnt <= r_cycleCnt + 32'd1;
         if (retire) r_instretCnt <= r_instretCnt + 32'd1;
      end
   end

   assign cycle_cnt   = r_cycleCnt;
   assign instret_cnt = r_instretCnt;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: expected per-cycle traces are built from the
// instruction class and memory wait counts, then replayed against the controller.
module tb_multicycle_ctrl;

   localparam int TMO = 15;
   localparam logic [6:0] OP_B  = 7'b1100011;
   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_S  = 7'b0100011;
   localparam logic [6:0] OP_L  = 7'b0000011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_J  = 7'b1101111;
   localparam logic [6:0] OP_JR = 7'b1100111;

   typedef struct packed {
      logic [2:0] st;
      logic       req, isInstr, rd, wr, irwr, pcwr;
      logic [1:0] pcsrc;
      logic       regwr, m2r, uj, aluSrc;
      logic [1:0] aluOp;
      logic       ill, ret;
   } out_t;

   typedef struct {
      string      name;
      logic [6:0] opc;
      logic       rdy;
      logic       br;
      out_t       exp;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, rst2, mem_ready, mem_ready2, branch_taken;
   logic [6:0] opcode;
   logic mem_req, mem_is_instr, MemRead, MemWr, IRWr, PCWr, RegWr, MemtoReg, UncondJump, ALUSrc;
   logic [1:0] PCSrc, ALUOp;
   logic [2:0] state;
   logic illegal, retire;
   logic mem_req2, mem_is_instr2, MemRead2, MemWr2, IRWr2, PCWr2, RegWr2, MemtoReg2, UncondJump2, ALUSrc2;
   logic [1:0] PCSrc2, ALUOp2;
   logic [2:0] state2;
   logic illegal2, retire2;
`ifdef MULTICYCLE_PERF_EN
   logic [31:0] cycle_cnt, instret_cnt, cycle_cnt2, instret_cnt2;
`endif

   multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .branch_taken(branch_taken),
      .mem_req(mem_req), .mem_is_instr(mem_is_instr), .MemRead(MemRead), .MemWr(MemWr),
      .IRWr(IRWr), .PCWr(PCWr), .PCSrc(PCSrc), .RegWr(RegWr), .MemtoReg(MemtoReg),
      .UncondJump(UncondJump), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .state(state),
      .illegal(illegal), .retire(retire)
`ifdef MULTICYCLE_PERF_EN
      , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
   );

   multicycle_ctrl #(.MEM_TIMEOUT(4)) dutShort (
      .clk(clk), .rst(rst2), .opcode(opcode), .mem_ready(mem_ready2), .branch_taken(branch_taken),
      .mem_req(mem_req2), .mem_is_instr(mem_is_instr2), .MemRead(MemRead2), .MemWr(MemWr2),
      .IRWr(IRWr2), .PCWr(PCWr2), .PCSrc(PCSrc2), .RegWr(RegWr2), .MemtoReg(MemtoReg2),
      .UncondJump(UncondJump2), .ALUSrc(ALUSrc2), .ALUOp(ALUOp2), .state(state2),
      .illegal(illegal2), .retire(retire2)
`ifdef MULTICYCLE_PERF_EN
      , .cycle_cnt(cycle_cnt2), .instret_cnt(instret_cnt2)
`endif
   );

   vec_t q[$];
   int totalCnt = 0;
   int passCnt  = 0;
   int expCyc   = 0;
   int expRet   = 0;

   function automatic logic [2:0] aluFor(input logic [6:0] opc);
      case (opc)
         OP_B:    return 3'b0_01;
         OP_R:    return 3'b0_10;
         OP_I:    return 3'b1_11;
         default: return 3'b1_00;
      endcase
   endfunction

   task automatic pushVec(input string name, input logic [6:0] opc, input logic rdy,
                          input logic br, input out_t e);
      vec_t v;
      v.name = name; v.opc = opc; v.rdy = rdy; v.br = br; v.exp = e;
      q.push_back(v);
   endtask

   task automatic pushError(input int n);
      out_t e;
      for (int i = 0; i < n; i++) begin
         e = '0; e.st = 3'd7; e.ill = 1'b1;
         pushVec("error", 7'($urandom), 1'($urandom), 1'($urandom), e);
      end
   endtask

   task automatic planFetch(input int waits);
      out_t e;
      e = '0; e.st = 3'd0; e.req = 1'b1; e.isInstr = 1'b1; e.rd = 1'b1;
      for (int i = 0; i < waits; i++) pushVec("fetch_wait", 7'($urandom), 1'b0, 1'($urandom), e);
      e.irwr = 1'b1; e.pcwr = 1'b1;
      pushVec("fetch_done", 7'($urandom), 1'b1, 1'($urandom), e);
   endtask

   task automatic planInstr(input logic [6:0] opc, input int fw, input int mw, input logic br);
      out_t e;
      logic [2:0] cls;
      logic isMem;
      cls = aluFor(opc);
      isMem = (opc == OP_L) || (opc == OP_S);
      planFetch(fw);
      e = '0; e.st = 3'd1;
      pushVec("decode", opc, 1'($urandom), 1'($urandom), e);
      e = '0; e.st = 3'd2; {e.aluSrc, e.aluOp} = cls;
      if (opc == OP_B) begin
         e.pcwr = br; e.pcsrc = 2'b01; e.ret = 1'b1;
      end else if (opc == OP_J || opc == OP_JR) begin
         e.pcwr = 1'b1; e.pcsrc = (opc == OP_JR) ? 2'b10 : 2'b01;
         e.regwr = 1'b1; e.uj = 1'b1; e.ret = 1'b1;
      end
      pushVec("exec", 7'($urandom), 1'($urandom), br, e);
      if (isMem) begin
         e = '0; e.st = 3'd3; e.req = 1'b1; e.aluSrc = 1'b1;
         e.rd = (opc == OP_L); e.wr = (opc == OP_S);
         for (int i = 0; i < mw && i < TMO; i++)
            pushVec("mem_wait", 7'($urandom), 1'b0, 1'($urandom), e);
         if (mw >= TMO) begin
            pushError(2);
            return;
         end
         e.ret = (opc == OP_S);
         pushVec("mem_done", 7'($urandom), 1'b1, 1'($urandom), e);
      end
      if (opc == OP_R || opc == OP_I || opc == OP_L) begin
         e = '0; e.st = 3'd4; e.regwr = 1'b1; e.m2r = (opc == OP_L); e.ret = 1'b1;
         {e.aluSrc, e.aluOp} = cls;
         pushVec("wb", 7'($urandom), 1'($urandom), 1'($urandom), e);
      end
   endtask

   task automatic checkOutput(input string name, input out_t e);
      out_t a;
      a.st = state; a.req = mem_req; a.isInstr = mem_is_instr; a.rd = MemRead; a.wr = MemWr;
      a.irwr = IRWr; a.pcwr = PCWr; a.pcsrc = PCSrc; a.regwr = RegWr; a.m2r = MemtoReg;
      a.uj = UncondJump; a.aluSrc = ALUSrc; a.aluOp = ALUOp; a.ill = illegal; a.ret = retire;
      totalCnt++;
      if (a === e) passCnt++;
      else $display("[TB] FAIL %s @%0t: got %h expected %h", name, $time, a, e);
   endtask

   task automatic checkScalar(input string name, input logic [31:0] act, input logic [31:0] exp);
      totalCnt++;
      if (act === exp) passCnt++;
      else $display("[TB] FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
   endtask

   task automatic applyStimulus(input vec_t v);
      opcode = v.opc; mem_ready = v.rdy; branch_taken = v.br;
      #1;
      checkOutput(v.name, v.exp);
`ifdef MULTICYCLE_PERF_EN
      checkScalar("cycle_cnt", cycle_cnt, 32'(expCyc));
      checkScalar("instret_cnt", instret_cnt, 32'(expRet));
`endif
      if (v.exp.st != 3'd7) expCyc++;
      if (v.exp.ret) expRet++;
      @(negedge clk);
   endtask

   task automatic runQueue();
      foreach (q[i]) applyStimulus(q[i]);
      q.delete();
   endtask

   task automatic doReset();
      rst = 1'b1; mem_ready = 1'b1; branch_taken = 1'b1; opcode = 7'($urandom);
      @(negedge clk);
      #1;
      checkOutput("reset", '0);
`ifdef MULTICYCLE_PERF_EN
      checkScalar("reset_cycle_cnt", cycle_cnt, 32'd0);
      checkScalar("reset_instret_cnt", instret_cnt, 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0; expCyc = 0; expRet = 0;
   endtask

   initial begin
      logic [6:0] ops [7];
      ops = '{OP_B, OP_R, OP_S, OP_L, OP_I, OP_J, OP_JR};
      rst = 1'b1; rst2 = 1'b1; mem_ready = 1'b0; mem_ready2 = 1'b0;
      opcode = 7'd0; branch_taken = 1'b0;
      doReset();

      // Directed instruction mix, including wait counts right at the timeout boundary.
      planInstr(OP_R, 0, 0, 1'b0);
      planInstr(OP_L, 0, 3, 1'b0);
      planInstr(OP_B, 0, 0, 1'b1);
      planInstr(OP_B, 0, 0, 1'b0);
      planInstr(OP_JR, 0, 0, 1'b1);
      planInstr(OP_J, 2, 0, 1'b0);
      planInstr(OP_I, TMO - 1, 0, 1'b0);
      planInstr(OP_S, 0, TMO - 1, 1'b0);
      runQueue();

      planFetch(0);
      begin
         out_t e;
         e = '0; e.st = 3'd1;
         pushVec("decode_bad", 7'h7F, 1'b0, 1'b0, e);
      end
      pushError(4);
      runQueue();
      doReset();

      planInstr(OP_L, 1, TMO, 1'b0);
      runQueue();
      doReset();

      begin
         out_t e;
         e = '0; e.st = 3'd0; e.req = 1'b1; e.isInstr = 1'b1; e.rd = 1'b1;
         for (int i = 0; i < TMO; i++) pushVec("fetch_tmo", 7'($urandom), 1'b0, 1'b0, e);
      end
      pushError(2);
      runQueue();
      doReset();

      // Store interrupted by reset in MEM: stop the trace at the first MEM wait cycle.
      planInstr(OP_S, 0, 3, 1'b0);
      while (q.size() > 4) void'(q.pop_back());
      runQueue();
      mem_ready = 1'b0;
      #1;
      checkScalar("sw_memwr_held", {31'd0, MemWr}, 32'd1);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("rst_mid_mem", '0);
`ifdef MULTICYCLE_PERF_EN
      checkScalar("rst_mid_cycle_cnt", cycle_cnt, 32'd0);
      checkScalar("rst_mid_instret_cnt", instret_cnt, 32'd0);
`endif
      doReset();

      for (int n = 0; n < 40; n++)
         planInstr(ops[$urandom_range(0, 6)], $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
      runQueue();

      // Short-timeout instance: four unanswered fetch cycles lead to ERROR.
      rst2 = 1'b0; mem_ready2 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         checkScalar("short_fetch_state", {29'd0, state2}, 32'd0);
         @(negedge clk);
      end
      #1;
      checkScalar("short_tmo_state", {29'd0, state2}, 32'd7);
      checkScalar("short_tmo_illegal", {31'd0, illegal2}, 32'd1);
      @(negedge clk);
      mem_ready2 = 1'b1;
      #1;
      checkScalar("short_tmo_sticky", {29'd0, state2}, 32'd7);

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
